// File: rtl/mgmt_spi_device.sv
// mgmt_spi_device: SPI mode-0 slave front end that deserialises MOSI bytes and serialises queued reply bytes onto MISO
module mgmt_spi_device #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_rx_data_valid,
  output logic [7:0] spi_rx_data,
  output logic       spi_cs_falling,
  output logic       spi_cs_n_sync,
  input  logic       spi_tx_data_valid,
  input  logic [7:0] spi_tx_data,
  output logic       spi_tx_overflow
);
  localparam int L = SYNC_STAGES - 1;
  logic [L:0] sck_sync, cs_sync, mosi_sync;
  logic [SYNC_STAGES:0] vld;
  logic sck_d, cs_d, mosi_d;
  logic sck_rise, sck_fall, cs_fall, cs_rise;
  logic active, en, load, last, tx_pend_valid;
  logic [2:0] bitcnt;
  logic [7:0] rx_shreg, rx_nxt, tx_shreg, tx_nxt, tx_pend;
  // synchronisers, delay flops and registered edge pulses; vld marks CS# samples that came from the pin, not from reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      vld       <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
      mosi_d    <= 1'b0;
      sck_rise  <= 1'b0;
      sck_fall  <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[L-1:0], spi_sck};
      cs_sync   <= {cs_sync[L-1:0], spi_cs_n};
      mosi_sync <= {mosi_sync[L-1:0], spi_mosi};
      vld       <= {vld[SYNC_STAGES-1:0], 1'b1};
      sck_d     <= sck_sync[L];
      cs_d      <= cs_sync[L];
      mosi_d    <= mosi_sync[L];
      sck_rise  <= sck_sync[L] & ~sck_d;
      sck_fall  <= ~sck_sync[L] & sck_d;
      cs_fall   <= ~cs_sync[L] & cs_d & vld[SYNC_STAGES];
      cs_rise   <= cs_sync[L] & ~cs_d;
    end
  end
  assign en             = active & ~cs_d;
  assign load           = en & sck_fall & (bitcnt == 3'd0);
  assign last           = en & sck_rise & (bitcnt == 3'd7);
  assign rx_nxt         = {rx_shreg[6:0], mosi_d};
  assign spi_cs_falling = cs_fall;
  assign spi_cs_n_sync  = cs_d;
  // next transmit shift value: clear on frame start, reload at byte boundary, else shift on SCK fall
  always_comb begin
    tx_nxt = cs_fall ? 8'h00 :
             load ? (spi_tx_data_valid ? spi_tx_data : (tx_pend_valid ? tx_pend : 8'h00)) :
             (en & sck_fall) ? {tx_shreg[6:0], 1'b0} : tx_shreg;
  end
  // frame state: receive shifter, bit counter, reply buffer and MISO
  always_ff @(posedge clk) begin
    if (rst) begin
      active            <= 1'b0;
      bitcnt            <= 3'd0;
      rx_shreg          <= 8'h00;
      tx_shreg          <= 8'h00;
      tx_pend           <= 8'h00;
      tx_pend_valid     <= 1'b0;
      spi_rx_data_valid <= 1'b0;
      spi_rx_data       <= 8'h00;
      spi_tx_overflow   <= 1'b0;
      spi_miso          <= 1'b0;
    end else begin
      active            <= cs_fall | (active & ~cs_rise);
      spi_rx_data_valid <= last;
      tx_shreg          <= tx_nxt;
      spi_miso          <= en & tx_nxt[7];
      if (cs_fall) begin
        bitcnt   <= 3'd0;
        rx_shreg <= 8'h00;
      end else if (en & sck_rise) begin
        bitcnt   <= bitcnt + 3'd1;
        rx_shreg <= rx_nxt;
      end
      if (last) spi_rx_data <= rx_nxt;
      if (spi_tx_data_valid & ~cs_fall & ~load) tx_pend <= spi_tx_data;
      tx_pend_valid   <= (cs_fall | load) ? 1'b0 : (tx_pend_valid | spi_tx_data_valid);
      spi_tx_overflow <= cs_fall ? 1'b0 : (spi_tx_overflow | (spi_tx_data_valid & ~load & tx_pend_valid));
    end
  end
endmodule

// File: doc/mgmt_spi_device.md
# mgmt_spi_device

Slave-side SPI front end between the STM32 management pins and the management protocol engine. It synchronises SCK, CS# and MOSI into `clk` and deserialises MOSI into byte strobes. It serialises reply bytes from the protocol engine onto MISO and reports CS# falling edges so the engine can resynchronise its command framing. The bus is SPI mode 0 (CPOL=0, CPHA=0), MSB first, with 8-bit frames.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages in each pin synchroniser; minimum 2.

Ports:
- `clk`  in  1  management engine clock.
- `rst`  in  1  reset, synchronous and active-high.
- `spi_sck`  in  1  SCK pin, asynchronous.
- `spi_cs_n`  in  1  CS# pin, asynchronous, active-low.
- `spi_mosi`  in  1  MOSI pin, asynchronous.
- `spi_miso`  out  1  MISO pin, registered.
- `spi_rx_data_valid`  out  1  one-cycle strobe: a complete byte was received.
- `spi_rx_data`  out  8  received byte; valid when the strobe is high, held until the next strobe.
- `spi_cs_falling`  out  1  one-cycle strobe on a synchronised CS# falling edge.
- `spi_cs_n_sync`  out  1  synchronised CS# level, for debug.
- `spi_tx_data_valid`  in  1  one-cycle strobe: queue `spi_tx_data` as the next reply byte.
- `spi_tx_data`  in  8  reply byte.
- `spi_tx_overflow`  out  1  sticky flag: a queued reply byte was overwritten before it was sent.

## Operation
- Each pin passes through `SYNC_STAGES` flops. One additional delay flop per pin provides edge detection: `sck_rise`, `sck_fall`, `cs_fall`, `cs_rise`.
- `bitcnt` (3 bit) counts SCK rising edges. `rx_shreg` (8 bit) holds incoming bits. `tx_shreg` (8 bit) holds outgoing bits. `tx_pend` (8 bit) and `tx_pend_valid` form a one-byte reply buffer.
- `cs_fall`:
  - Pulse `spi_cs_falling`.
  - Clear `bitcnt`, `rx_shreg`, `tx_pend_valid` and `spi_tx_overflow`.
  - Load `tx_shreg` with 0x00.
- `cs_rise`, or CS# high:
  - Ignore SCK edges.
  - Discard a partial byte; no strobe is produced.
  - Force `spi_miso` to 0.
- `sck_rise` with CS# low:
  - Shift the synchronised MOSI into `rx_shreg` LSB.
  - Increment `bitcnt`.
  - When `bitcnt` was 7: pulse `spi_rx_data_valid` with `{rx_shreg[6:0], mosi}` and wrap `bitcnt` to 0.
- `sck_fall` with CS# low:
  - If `bitcnt`==0 (byte boundary): load `tx_shreg` from `tx_pend` if `tx_pend_valid`, else 0x00. Then clear `tx_pend_valid`.
  - Otherwise: shift `tx_shreg` left, filling with 0.
- `spi_miso` is registered from `tx_shreg[7]`.
- Reply bytes are therefore one byte behind. A byte queued after byte N is received goes out during byte N+1. Byte boundaries with nothing queued send 0x00.
- `spi_tx_data_valid`:
  - Write `tx_pend`; set `tx_pend_valid`.
  - If `tx_pend_valid` was already set and not consumed this cycle, set `spi_tx_overflow`.
  - If it coincides with a byte-boundary load, the new byte goes straight to `tx_shreg` and `tx_pend_valid` stays 0.
  - If it coincides with `cs_fall`, it is dropped.
- `rst` values:
  - Outputs: `spi_miso`=0, `spi_rx_data_valid`=0, `spi_rx_data`=0x00, `spi_cs_falling`=0, `spi_cs_n_sync`=1, `spi_tx_overflow`=0.
  - Internal state: `bitcnt`=0, shift registers=0, `tx_pend_valid`=0.
  - Synchroniser flops reset to 1 for CS#, 0 for SCK and MOSI.
  - If `rst` is asserted mid-transfer, the remainder of that CS# frame is ignored until the next `cs_fall`. No strobes are produced for it.

## Timing
- Pin edge to internal edge pulse: SYNC_STAGES+1 clk.
- Eighth SCK rising edge at the pin to `spi_rx_data_valid`: SYNC_STAGES+2 clk.
- SCK falling edge at the pin to `spi_miso` update: SYNC_STAGES+2 clk.
- Electrical requirements on the master:
  - SCK high and low times ≥ SYNC_STAGES+4 clk.
  - CS# fall to first SCK rise ≥ SYNC_STAGES+4 clk.
- A reply byte must be queued before the first `sck_fall` after the `spi_rx_data_valid` strobe. The engine responds in 2 clk, which the low-time rule covers.
- No backpressure exists. Strobes are fire-and-forget.

## Test plan
- Reset, CS# high, SCK idle → all outputs at reset values; `spi_cs_n_sync`=1; no strobes for 20 clk.
- CS# fall, then MOSI bytes 0x01,0x00 at SCK = clk/12 → one `spi_cs_falling`, then strobes with 0x01 then 0x00, each SYNC_STAGES+2 clk after the 8th SCK rise; MISO reads 0x00 0x00.
- During a 4-byte transfer, queue 0x55 two clk after strobe 2 → MISO byte 3 = 0x55; bytes 1, 2 and 4 = 0x00.
- Queue 0xAA then 0x3C before the next boundary → MISO sends 0x3C; `spi_tx_overflow`=1 until the next CS# fall.
- CS# rises after 5 bits of 0xFF, then a new frame sends 0xA5 → no strobe for the partial byte; the new frame strobes exactly 0xA5.
- `rst` pulsed after 3 bits, frame continues, then a new frame sends 0x12 → no strobes until the new CS# fall; the 0x12 strobe is then correct.
